// File: rtl/regfile_dump_reader.sv
// Walks a register-file read port from FIRST_REG to LAST_REG and streams each
// value with its index over a valid/ready interface.
module regfile_dump_reader #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

    state_e state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            rd_addr   <= FirstAddr;
        end else if (abort && state_q != StIdle) begin
            // A word presented alongside abort is dropped, never counted as accepted.
            state_q   <= StIdle;
            out_valid <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= FirstAddr;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rd_addr <= FirstAddr;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    out_data  <= rd_data;
                    out_addr  <= rd_addr;
                    out_valid <= 1'b1;
                    state_q   <= StSend;
                end
                StSend: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_addr == LastAddr) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    rd_addr <= FirstAddr;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, backpressure, ignored start,
// abort, asynchronous reset and a single-register configuration.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready, start1;
    logic        busy, done, out_valid, busy1, done1, out_valid1;
    logic [4:0]  rd_addr, out_addr, rd_addr1, out_addr1;
    logic [31:0] rd_data, out_data, rd_data1, out_data1;
    logic [31:0] regs [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rd_data  = regs[rd_addr];
    assign rd_data1 = regs[rd_addr1];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(5), .LAST_REG(5)) u_one (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .busy(busy1), .done(done1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_addr(out_addr1), .out_data(out_data1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: busy/done/valid got %b want 000", {busy, done, out_valid});
        end
        vectors++;
        if ({out_addr, out_data, rd_addr} !== {5'd0, 32'd0, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_regs: addr=%0d data=%h rd_addr=%0d want 0/0/0",
                     out_addr, out_data, rd_addr);
        end
        vectors++;
        if (rd_addr1 !== 5'd5) begin
            miscompares++;
            $display("FAIL reset_rd_addr_first: got %0d want 5", rd_addr1);
        end
    endtask

    task automatic test_full_dump();
        for (int k = 0; k < 32; k++) regs[k] = 32'h100 + k;
        out_ready = 1'b1;
        start = 1'b1;
        tick();  // after E0
        start = 1'b0;
        vectors++;
        if ({busy, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_after_start: busy/valid got %b want 10", {busy, out_valid});
        end
        for (int i = 0; i < 32; i++) begin
            tick();  // after E(2i+1): word i presented
            vectors++;
            if ({out_valid, out_addr, out_data} !== {1'b1, 5'(i), 32'(32'h100 + i)}) begin
                miscompares++;
                $display("FAIL full_word%0d: valid=%b addr=%0d data=%h want 1/%0d/%h",
                         i, out_valid, out_addr, out_data, i, 32'h100 + i);
            end
            tick();  // after E(2i+2): word i accepted
            vectors++;
            if ({out_valid, busy, done} !== {1'b0, 1'b1, (i == 31)}) begin
                miscompares++;
                $display("FAIL full_accept%0d: valid/busy/done got %b want 01%0b",
                         i, {out_valid, busy, done}, (i == 31));
            end
        end
        tick();  // after E65
        vectors++;
        if ({done, busy, rd_addr} !== {1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL full_end: done=%b busy=%b rd_addr=%0d want 0/0/0", done, busy, rd_addr);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0, bad = 0;
        bit held = 0;
        for (int k = 0; k < 32; k++) regs[k] = k + 1;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && busy; c++) begin
            tick();
            if (out_valid && out_addr == 5'd3 && !held) begin
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    vectors++;
                    if ({out_valid, out_addr, out_data} !== {1'b1, 5'd3, 32'h4}) begin
                        miscompares++;
                        $display("FAIL bp_hold%0d: valid=%b addr=%0d data=%h want 1/3/4",
                                 h, out_valid, out_addr, out_data);
                    end
                end
                out_ready = 1'b1;
                held = 1;
            end
            if (out_valid && out_ready) begin
                if (out_addr !== 5'(idx) || out_data !== 32'(idx + 1)) bad++;
                idx++;
            end
        end
        vectors++;
        if (idx !== 32 || bad !== 0 || !held) begin
            miscompares++;
            $display("FAIL bp_sequence: words=%0d bad=%0d held=%0b want 32/0/1", idx, bad, held);
        end
    endtask

    task automatic test_start_ignored();
        int idx = 0, bad = 0, dones = 0;
        for (int k = 0; k < 32; k++) regs[k] = 32'hA000 + k;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 200 && busy; c++) begin
            tick();
            start = (c == 10);
            if (done) dones++;
            if (out_valid && out_ready) begin
                if (out_addr !== 5'(idx) || out_data !== 32'(32'hA000 + idx)) bad++;
                idx++;
            end
        end
        start = 1'b0;
        vectors++;
        if (idx !== 32 || bad !== 0) begin
            miscompares++;
            $display("FAIL restart_words: words=%0d bad=%0d want 32/0", idx, bad);
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL restart_done_count: got %0d want 1", dones);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_not_queued: busy got %b want 0", busy);
        end
    endtask

    task automatic test_abort();
        bit found = 0;
        for (int k = 0; k < 32; k++) regs[k] = 32'h100 + k;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (out_valid && out_addr == 5'd7) found = 1;
        end
        out_ready = 1'b0;
        vectors++;
        if (!found || out_data !== 32'h107) begin
            miscompares++;
            $display("FAIL abort_reach7: found=%0b data=%h want 1/107", found, out_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, out_valid, done, rd_addr} !== {3'b000, 5'd0}) begin
            miscompares++;
            $display("FAIL abort_drop: busy/valid/done=%b rd_addr=%0d want 000/0",
                     {busy, out_valid, done}, rd_addr);
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_no_done: busy/done got %b want 00", {busy, done});
        end
        out_ready = 1'b1;
        start = 1'b1;
        abort = 1'b1;  // abort in IDLE must not block this start
        tick();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_idle_start: busy got %b want 1", busy);
        end
        tick();
        vectors++;
        if ({out_valid, out_addr, out_data} !== {1'b1, 5'd0, 32'h100}) begin
            miscompares++;
            $display("FAIL abort_restart0: valid=%b addr=%0d data=%h want 1/0/100",
                     out_valid, out_addr, out_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();  // after E5: word 2 presented
        vectors++;
        if ({busy, out_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL arst_pre: busy/valid got %b want 11", {busy, out_valid});
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, out_valid, done, rd_addr, out_addr, out_data} !== {3'b000, 5'd0, 5'd0, 32'd0})
        begin
            miscompares++;
            $display("FAIL arst_drop: busy/valid/done=%b rd_addr=%0d addr=%0d data=%h want 0s",
                     {busy, out_valid, done}, rd_addr, out_addr, out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL arst_idle: busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_single_reg();
        regs[5] = 32'hDEAD;
        out_ready = 1'b1;
        start1 = 1'b1;
        tick();  // after E0
        start1 = 1'b0;
        vectors++;
        if ({busy1, out_valid1} !== 2'b10) begin
            miscompares++;
            $display("FAIL one_start: busy/valid got %b want 10", {busy1, out_valid1});
        end
        tick();  // after E1
        vectors++;
        if ({out_valid1, out_addr1, out_data1} !== {1'b1, 5'd5, 32'hDEAD}) begin
            miscompares++;
            $display("FAIL one_word: valid=%b addr=%0d data=%h want 1/5/dead",
                     out_valid1, out_addr1, out_data1);
        end
        tick();  // after E2
        vectors++;
        if ({done1, out_valid1, busy1} !== 3'b101) begin
            miscompares++;
            $display("FAIL one_done: done/valid/busy got %b want 101", {done1, out_valid1, busy1});
        end
        tick();  // after E3
        vectors++;
        if ({done1, busy1, rd_addr1} !== {2'b00, 5'd5}) begin
            miscompares++;
            $display("FAIL one_idle: done/busy=%b rd_addr=%0d want 00/5", {done1, busy1}, rd_addr1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = '0;
        repeat (2) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_full_dump();
        tick();
        test_backpressure();
        tick();
        test_start_ignored();
        tick();
        test_abort();
        tick();
        test_async_reset();
        tick();
        test_single_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
